// File: rtl/irq_if.sv
// Interrupt controller bus: request lines, mask/enable controls, CPU handshake and status.
interface irq_if #(
   parameter int unsigned NUM_IRQ = 8
);
   localparam int unsigned ID_W = $clog2(NUM_IRQ);

   logic [NUM_IRQ-1:0] irq_in;
   logic [NUM_IRQ-1:0] edge_mode;
   logic               mask_wr;
   logic [NUM_IRQ-1:0] mask_data;
   logic               ien_set;
   logic               ien_clr;
   logic               int_ack;
   logic               int_done;
   logic               Interrupts;
   logic [ID_W-1:0]    int_id;
   logic [31:0]        int_vector;
   logic               in_service;
   logic [NUM_IRQ-1:0] pending_q;
   logic [NUM_IRQ-1:0] mask_q;
   logic               ien_q;

   // Requesters / control unit side
   modport master (
      output irq_in, edge_mode, mask_wr, mask_data, ien_set, ien_clr, int_ack, int_done,
      input  Interrupts, int_id, int_vector, in_service, pending_q, mask_q, ien_q
   );

   // Controller side
   modport slave (
      input  irq_in, edge_mode, mask_wr, mask_data, ien_set, ien_clr, int_ack, int_done,
      output Interrupts, int_id, int_vector, in_service, pending_q, mask_q, ien_q
   );
endinterface

// File: rtl/irq_controller.sv
// Non-nested interrupt controller: edge/level capture, masking, fixed priority,
// request/ack/done handshake and handler vector generation.
module irq_controller #(
   parameter int unsigned NUM_IRQ    = 8,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'd4
) (
   input logic   Clock,
   input logic   Reset,
   irq_if.slave  bus
);
   localparam int unsigned ID_W = $clog2(NUM_IRQ);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             state;
   logic [NUM_IRQ-1:0] irq_prev;
   logic [NUM_IRQ-1:0] pend;
   logic [NUM_IRQ-1:0] msk;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] eligible;
   logic [ID_W-1:0]    winner;
   logic [ID_W-1:0]    id;
   logic [31:0]        vec;
   logic               any_elig;
   logic               req;
   logic               svc;
   logic               ien;
   logic               ien_saved;
   logic               ack_fire;

   assign rise     = bus.irq_in & ~irq_prev;
   assign eligible = pend & ~msk;
   assign any_elig = |eligible;
   assign ack_fire = (state == REQ) && bus.int_ack && ien && any_elig;

   // Lowest eligible index wins
   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) winner = ID_W'(i);
      end
   end

   // Pending capture, mask/enable registers and request/service FSM
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         irq_prev  <= '0;
         pend      <= '0;
         msk       <= '1;
         id        <= '0;
         vec       <= VEC_BASE;
         req       <= 1'b0;
         svc       <= 1'b0;
         ien       <= 1'b0;
         ien_saved <= 1'b0;
      end else begin
         irq_prev <= bus.irq_in;
         if (bus.mask_wr) msk <= bus.mask_data;

         // A fresh edge beats a same-cycle ack clear; level lines just follow the input
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.edge_mode[i]) begin
               if (rise[i])
                  pend[i] <= 1'b1;
               else if (ack_fire && (winner == ID_W'(i)))
                  pend[i] <= 1'b0;
            end else begin
               pend[i] <= bus.irq_in[i];
            end
         end

         // EI/DI are frozen while a handler runs
         if (state != SERVICE) begin
            if (bus.ien_clr)      ien <= 1'b0;
            else if (bus.ien_set) ien <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (ien && any_elig) begin
                  req   <= 1'b1;
                  state <= REQ;
               end
            end
            REQ: begin
               if (!ien || !any_elig) begin
                  req   <= 1'b0;
                  state <= IDLE;
               end else if (bus.int_ack) begin
                  id        <= winner;
                  vec       <= VEC_BASE + 32'(winner) * VEC_STRIDE;
                  ien_saved <= ien;
                  ien       <= 1'b0;
                  req       <= 1'b0;
                  svc       <= 1'b1;
                  state     <= SERVICE;
               end
            end
            SERVICE: begin
               if (bus.int_done) begin
                  ien   <= ien_saved;
                  svc   <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               req   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.Interrupts = req;
   assign bus.int_id     = id;
   assign bus.int_vector = vec;
   assign bus.in_service = svc;
   assign bus.pending_q  = pend;
   assign bus.mask_q     = msk;
   assign bus.ien_q      = ien;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; ack results are checked through an expected-ID queue.
module tb_irq_controller;
   localparam int unsigned NUM_IRQ = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;
   int   exp_q[$];

   irq_if #(.NUM_IRQ(NUM_IRQ)) bus ();

   irq_controller #(
      .NUM_IRQ(NUM_IRQ),
      .VEC_BASE(32'h0000_0100),
      .VEC_STRIDE(32'd4)
   ) dut (
      .Clock(clk),
      .Reset(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic wait_req(input string tag, input int budget);
      int n = 0;
      while (bus.Interrupts !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(bus.Interrupts), 32'd1);
   endtask

   // Pulse int_ack (optionally with int_done), queueing the ID the controller should grant
   task automatic do_ack(input int exp_id, input logic with_done);
      exp_q.push_back(exp_id);
      bus.int_ack  = 1'b1;
      bus.int_done = with_done;
      tick();
      bus.int_ack  = 1'b0;
      bus.int_done = 1'b0;
   endtask

   task automatic check_ack(input string tag);
      int e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_id"}, 32'(bus.int_id), 32'(e));
         chk({tag, "_vec"}, bus.int_vector, 32'h0000_0100 + 32'(e) * 32'd4);
         chk({tag, "_svc"}, 32'(bus.in_service), 32'd1);
         chk({tag, "_req"}, 32'(bus.Interrupts), 32'd0);
      end
   endtask

   task automatic do_done();
      bus.int_done = 1'b1;
      tick();
      bus.int_done = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req"},  32'(bus.Interrupts), 32'd0);
      chk({tag, "_id"},   32'(bus.int_id), 32'd0);
      chk({tag, "_vec"},  bus.int_vector, 32'h0000_0100);
      chk({tag, "_svc"},  32'(bus.in_service), 32'd0);
      chk({tag, "_pend"}, 32'(bus.pending_q), 32'd0);
      chk({tag, "_mask"}, 32'(bus.mask_q), 32'h0000_00FF);
      chk({tag, "_ien"},  32'(bus.ien_q), 32'd0);
   endtask

   initial begin
      bus.irq_in    = '0;
      bus.edge_mode = 8'b1111_1101;   // line 1 level, others edge
      bus.mask_wr   = 1'b0;
      bus.mask_data = '0;
      bus.ien_set   = 1'b0;
      bus.ien_clr   = 1'b0;
      bus.int_ack   = 1'b0;
      bus.int_done  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check_reset("rst");

      // DI beats EI
      bus.ien_set = 1'b1;
      bus.ien_clr = 1'b1;
      tick();
      bus.ien_clr = 1'b0;
      chk("ien_clr_prio", 32'(bus.ien_q), 32'd0);

      // 1: enable, unmask, edge on line 3
      bus.mask_wr = 1'b1;
      tick();
      bus.ien_set = 1'b0;
      bus.mask_wr = 1'b0;
      chk("t1_ien", 32'(bus.ien_q), 32'd1);
      chk("t1_mask", 32'(bus.mask_q), 32'd0);
      bus.irq_in = 8'h08;
      tick();
      bus.irq_in = 8'h00;
      chk("t1_pend", 32'(bus.pending_q), 32'h08);
      chk("t1_req_early", 32'(bus.Interrupts), 32'd0);
      tick();
      chk("t1_req", 32'(bus.Interrupts), 32'd1);
      do_ack(3, 1'b0);
      check_ack("t1_ack");
      chk("t1_pend_clr", 32'(bus.pending_q), 32'd0);
      chk("t1_ien_off", 32'(bus.ien_q), 32'd0);
      do_done();
      chk("t1_done_ien", 32'(bus.ien_q), 32'd1);
      chk("t1_done_svc", 32'(bus.in_service), 32'd0);

      // 2: lines 5 and 2 together, priority then re-request
      bus.irq_in = 8'h24;
      tick();
      bus.irq_in = 8'h00;
      chk("t2_pend", 32'(bus.pending_q), 32'h24);
      wait_req("t2_req1", 3);
      do_ack(2, 1'b0);
      check_ack("t2_ack1");
      chk("t2_pend_left", 32'(bus.pending_q), 32'h20);
      do_done();
      wait_req("t2_req2", 2);
      do_ack(5, 1'b0);
      check_ack("t2_ack2");
      do_done();

      // 3: level line withdrawn before ack
      bus.irq_in = 8'h02;
      tick();
      chk("t3_pend", 32'(bus.pending_q), 32'h02);
      tick();
      chk("t3_req", 32'(bus.Interrupts), 32'd1);
      bus.irq_in = 8'h00;
      tick();
      tick();
      chk("t3_req_drop", 32'(bus.Interrupts), 32'd0);
      chk("t3_pend_zero", 32'(bus.pending_q), 32'd0);
      chk("t3_svc", 32'(bus.in_service), 32'd0);

      // 4: masked edge stays latched and fires on unmask
      bus.mask_wr   = 1'b1;
      bus.mask_data = 8'hFF;
      tick();
      bus.mask_wr   = 1'b0;
      bus.irq_in    = 8'h40;
      tick();
      bus.irq_in    = 8'h00;
      tick();
      tick();
      chk("t4_masked_req", 32'(bus.Interrupts), 32'd0);
      chk("t4_masked_pend", 32'(bus.pending_q), 32'h40);
      bus.mask_wr   = 1'b1;
      bus.mask_data = 8'h00;
      tick();
      bus.mask_wr   = 1'b0;
      chk("t4_mask_clr", 32'(bus.mask_q), 32'd0);
      tick();
      chk("t4_req", 32'(bus.Interrupts), 32'd1);
      do_ack(6, 1'b0);
      check_ack("t4_ack");

      // 5: edge plus spurious ack in SERVICE
      bus.irq_in = 8'h01;
      bus.int_ack = 1'b1;
      tick();
      bus.irq_in = 8'h00;
      bus.int_ack = 1'b0;
      chk("t5_id_hold", 32'(bus.int_id), 32'd6);
      chk("t5_svc_hold", 32'(bus.in_service), 32'd1);
      chk("t5_pend", 32'(bus.pending_q), 32'h01);
      tick();
      chk("t5_no_req", 32'(bus.Interrupts), 32'd0);
      do_done();
      chk("t5_ien_restore", 32'(bus.ien_q), 32'd1);
      wait_req("t5_req", 3);
      // ack and done together in REQ: only ack acts
      do_ack(0, 1'b1);
      check_ack("t5_ack");
      chk("t5_pend_clr", 32'(bus.pending_q), 32'd0);

      // 6: reset aborts service
      rst = 1'b1;
      tick();
      check_reset("t6");
      rst = 1'b0;
      bus.int_done = 1'b1;
      tick();
      bus.int_done = 1'b0;
      chk("t6_idle_req", 32'(bus.Interrupts), 32'd0);
      chk("t6_idle_svc", 32'(bus.in_service), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
